// File: rtl/baseerat_pkg.sv
// Shared definitions for the baseerat demultiplexer: route encodings and
// the depth of each per-output buffer.
package baseerat_pkg;

  typedef enum logic {
    ROUTE0 = 1'b0,
    ROUTE1 = 1'b1
  } route_e;

  localparam int DEMUX_DEPTH = 2;

endpackage

// File: rtl/baseerat_demux_fifo2.sv
// Two-entry FIFO with a registered (non fall-through) empty flag. A write
// while full is accepted only when the same edge also pops.
module baseerat_demux_fifo2
  import baseerat_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEMUX_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  wr_fire;
  logic                  rd_fire;

  assign full    = (count == 2'(DEMUX_DEPTH));
  assign empty   = (count == 2'd0);
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr_en & (~full | rd_fire);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_fire) wr_ptr <= ~wr_ptr;
      if (rd_fire) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr_fire} - {1'b0, rd_fire};
    end
  end

  // NOTE: the storage array is deliberately not reset; stale contents are
  // unobservable because the read port is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/baseerat_demux.sv
// 1-to-2 demultiplexer with valid/ready handshakes: each input word is routed
// by sel into one of two 2-entry output buffers, optionally via a stage register.
module baseerat_demux
  import baseerat_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int unsigned REG_OUT    = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  sel,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout0_valid,
  output logic                  dout1_valid,
  input  logic                  dout0_ready,
  input  logic                  dout1_ready
);

  logic [1:0]            full;
  logic [1:0]            empty;
  logic [1:0]            pop;
  logic [1:0]            space;
  logic [1:0]            wr_en;
  logic                  wr_valid;
  route_e                wr_sel;
  logic [DATA_WIDTH-1:0] wr_data;

  assign dout0_valid = ~empty[0];
  assign dout1_valid = ~empty[1];
  assign pop         = {dout1_valid & dout1_ready, dout0_valid & dout0_ready};
  // A full buffer still has room this edge if its head is leaving.
  assign space       = ~full | pop;
  assign wr_en[0]    = wr_valid & (wr_sel == ROUTE0);
  assign wr_en[1]    = wr_valid & (wr_sel == ROUTE1);

  generate
    if (REG_OUT == 0) begin : g_direct
      assign din_ready = ~resetn & space[sel];
      assign wr_valid  = din_valid & din_ready;
      assign wr_sel    = route_e'(sel);
      assign wr_data   = din;
    end else begin : g_stage
      logic                  stage_valid;
      logic                  stage_sel;
      logic [DATA_WIDTH-1:0] stage_data;
      logic                  drain;
      logic                  load;

      assign drain     = stage_valid & space[stage_sel];
      assign din_ready = ~resetn & (~stage_valid | space[stage_sel]);
      assign load      = din_valid & din_ready;

      always_ff @(posedge clk) begin
        if (resetn) begin
          stage_valid <= 1'b0;
        end else if (load) begin
          stage_valid <= 1'b1;
        end else if (drain) begin
          stage_valid <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (load) begin
          stage_data <= din;
          stage_sel  <= sel;
        end
      end

      assign wr_valid = drain;
      assign wr_sel   = route_e'(stage_sel);
      assign wr_data  = stage_data;
    end
  endgenerate

  baseerat_demux_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo0 (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en[0]),
    .wr_data (wr_data),
    .full    (full[0]),
    .rd_en   (pop[0]),
    .rd_data (dout0),
    .empty   (empty[0])
  );

  baseerat_demux_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo1 (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en[1]),
    .wr_data (wr_data),
    .full    (full[1]),
    .rd_en   (pop[1]),
    .rd_data (dout1),
    .empty   (empty[1])
  );

endmodule

// File: tb/tb_baseerat_demux.sv
// Drives a REG_OUT=0 and a REG_OUT=1 instance with shared stimulus and checks
// both against a queue-based reference model of the demultiplexer.
module tb_baseerat_demux;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] din;
  logic        sel;
  logic        din_valid;
  logic        rdy0;
  logic        rdy1;

  logic        d_ready [2];
  logic [15:0] d_dout  [2][2];
  logic        d_valid [2][2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  baseerat_demux #(.DATA_WIDTH(16), .REG_OUT(0)) u_dut_a (
    .clk         (clk),
    .resetn      (resetn),
    .din         (din),
    .sel         (sel),
    .din_valid   (din_valid),
    .din_ready   (d_ready[0]),
    .dout0       (d_dout[0][0]),
    .dout1       (d_dout[0][1]),
    .dout0_valid (d_valid[0][0]),
    .dout1_valid (d_valid[0][1]),
    .dout0_ready (rdy0),
    .dout1_ready (rdy1)
  );

  baseerat_demux #(.DATA_WIDTH(16), .REG_OUT(1)) u_dut_b (
    .clk         (clk),
    .resetn      (resetn),
    .din         (din),
    .sel         (sel),
    .din_valid   (din_valid),
    .din_ready   (d_ready[1]),
    .dout0       (d_dout[1][0]),
    .dout1       (d_dout[1][1]),
    .dout0_valid (d_valid[1][0]),
    .dout1_valid (d_valid[1][1]),
    .dout0_ready (rdy0),
    .dout1_ready (rdy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: words held per output are plain queues; for the staged
  // instance one extra slot ahead of the queues holds the newest word.
  logic [15:0] bq [2][2][$];
  logic        st_v    [2];
  logic        st_sel  [2];
  logic [15:0] st_data [2];
  logic        prev_rst = 1'b1;
  logic        model_on = 1'b0;
  logic [1:0]  m_pop;
  logic [1:0]  m_spc;
  logic        m_rdy;
  logic        m_vld;

  initial begin
    st_v[0] = 1'b0;
    st_v[1] = 1'b0;
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int d = 0; d < 2; d++) begin
        for (int o = 0; o < 2; o++) begin
          m_vld = (bq[d][o].size() > 0);
          check($sformatf("dut%0d dout%0d_valid", d, o), 32'(d_valid[d][o]), 32'(m_vld));
          if (m_vld)
            check($sformatf("dut%0d dout%0d data", d, o), 32'(d_dout[d][o]), 32'(bq[d][o][0]));
          if (prev_rst)
            check($sformatf("dut%0d dout%0d reset value", d, o), 32'(d_dout[d][o]), 32'h0);
          m_pop[o] = m_vld & ((o == 0) ? rdy0 : rdy1);
          m_spc[o] = (bq[d][o].size() < 2) | m_pop[o];
        end
        if (resetn)      m_rdy = 1'b0;
        else if (d == 0) m_rdy = m_spc[sel];
        else             m_rdy = ~st_v[d] | m_spc[st_sel[d]];
        check($sformatf("dut%0d din_ready", d), 32'(d_ready[d]), 32'(m_rdy));

        if (resetn) begin
          bq[d][0].delete();
          bq[d][1].delete();
          st_v[d] = 1'b0;
        end else begin
          for (int o = 0; o < 2; o++)
            if (m_pop[o]) void'(bq[d][o].pop_front());
          if (d == 0) begin
            if (din_valid && m_rdy) bq[d][sel].push_back(din);
          end else begin
            if (st_v[d] && m_spc[st_sel[d]]) begin
              bq[d][st_sel[d]].push_back(st_data[d]);
              st_v[d] = 1'b0;
            end
            if (din_valid && m_rdy) begin
              st_v[d]    = 1'b1;
              st_sel[d]  = sel;
              st_data[d] = din;
            end
          end
        end
      end
      prev_rst = resetn;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive(input logic [15:0] data, input logic s, input logic v);
    din       = data;
    sel       = s;
    din_valid = v;
  endtask

  initial begin
    resetn = 1'b1;
    rdy0   = 1'b0;
    rdy1   = 1'b0;
    drive(16'h0, 1'b0, 1'b0);
    cycles(2);
    model_on = 1'b1;
    cycle();
    resetn = 1'b0;
    cycle();

    // Simple routing with both consumers ready.
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    drive(16'h1111, 1'b0, 1'b1);
    cycle();
    drive(16'h2222, 1'b1, 1'b1);
    @(negedge clk);
    check("direct dout0 latency valid", 32'(d_valid[0][0]), 32'h1);
    check("direct dout0 latency data", 32'(d_dout[0][0]), 32'h1111);
    cycle();
    drive(16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("direct dout1 latency valid", 32'(d_valid[0][1]), 32'h1);
    check("direct dout1 latency data", 32'(d_dout[0][1]), 32'h2222);
    cycles(4);

    // Fill buffer 0 and hold it, then head-of-line and pop-with-write cases.
    rdy0 = 1'b0;
    drive(16'hA001, 1'b0, 1'b1);
    cycle();
    drive(16'hA002, 1'b0, 1'b1);
    cycle();
    drive(16'hA003, 1'b0, 1'b1);
    @(negedge clk);
    check("full buffer0 blocks din_ready", 32'(d_ready[0]), 32'h0);
    cycles(2);
    drive(16'hB001, 1'b1, 1'b1);
    @(negedge clk);
    check("other buffer accepts", 32'(d_ready[0]), 32'h1);
    cycle();
    drive(16'hA003, 1'b0, 1'b1);
    @(negedge clk);
    check("head-of-line din_ready", 32'(d_ready[0]), 32'h0);
    cycles(2);
    rdy0 = 1'b1;
    drive(16'hC0DE, 1'b0, 1'b1);
    @(negedge clk);
    check("full buffer with pop accepts", 32'(d_ready[0]), 32'h1);
    cycle();
    rdy0 = 1'b0;
    drive(16'h0, 1'b0, 1'b0);
    cycles(2);
    rdy0 = 1'b1;
    cycles(6);

    // One word per buffer, then a single reset cycle discards them.
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    drive(16'h0D01, 1'b0, 1'b1);
    cycle();
    drive(16'h0D02, 1'b1, 1'b1);
    cycle();
    drive(16'h0, 1'b0, 1'b0);
    cycle();
    resetn = 1'b1;
    cycle();
    resetn = 1'b0;
    rdy0   = 1'b1;
    rdy1   = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int o = 0; o < 2; o++)
        check($sformatf("dut%0d dout%0d valid after reset", d, o), 32'(d_valid[d][o]), 32'h0);
    cycles(4);

    // Staged latency on an empty block.
    rdy1 = 1'b0;
    drive(16'h5A5A, 1'b1, 1'b1);
    cycle();
    drive(16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("staged dout1_valid one cycle after accept", 32'(d_valid[1][1]), 32'h0);
    check("direct dout1_valid one cycle after accept", 32'(d_valid[0][1]), 32'h1);
    cycle();
    @(negedge clk);
    check("staged dout1_valid two cycles after accept", 32'(d_valid[1][1]), 32'h1);
    check("staged dout1 data", 32'(d_dout[1][1]), 32'h5A5A);
    rdy1 = 1'b1;
    cycles(3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(16'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7));
      rdy0   = ($urandom_range(0, 9) < 6);
      rdy1   = ($urandom_range(0, 9) < 6);
      resetn = ($urandom_range(0, 99) == 0);
      cycle();
    end

    resetn = 1'b0;
    drive(16'h0, 1'b0, 1'b0);
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    cycles(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
